data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: word-addressed RAM answering load/store requests
// over a valid/ready handshake with a fixed read latency and a stall hint.
module data_mem_responder #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             err,
  output logic             stall
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0] DEPTH_W = (WIDTH+1)'(DEPTH);
  localparam logic [3:0]     LAT_M1  = 4'(READ_LAT - 1);
  localparam bit             SINGLE  = (READ_LAT == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pend_data;
  logic             pend_oor;
  logic             in_range;
  logic             load_acc;
  logic             store_acc;
  logic             resp_nxt;
  logic [WIDTH-1:0] rd_word;
  logic [AW-1:0]    idx;

  // Range decided on the full address so high bits never alias into the RAM.
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  assign idx       = req_addr[AW-1:0];
  assign rd_word   = in_range ? mem[idx] : '0;

  assign req_ready = (state != WAIT);
  assign stall     = req_valid & ~req_ready;
  assign load_acc  = req_valid & req_ready & ~req_we;
  assign store_acc = req_valid & req_ready & req_we;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    resp_nxt  = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (load_acc) begin
          if (SINGLE) begin
            resp_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          resp_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rsp_valid is registered so the single-cycle latency can pipeline from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
      pend_data <= '0;
      pend_oor  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= resp_nxt;
      err       <= (store_acc & ~in_range) |
                   (resp_nxt & (SINGLE ? ~in_range : pend_oor));
      if (load_acc) begin
        pend_data <= rd_word;
        pend_oor  <= ~in_range;
      end
      if (resp_nxt) begin
        rsp_rdata <= SINGLE ? rd_word : pend_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_acc && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (READ_LAT 1, 2, 3) driven by one stimulus
// process; a negedge monitor pops expected responses and checks handshakes.
module tb_data_mem_responder;

  localparam int W = 24;
  localparam int D = 1024;

  typedef struct {
    bit           is_load;
    logic [W-1:0] data;
    bit           err;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  int           cyc = 0;

  logic         rv   [3];
  logic         rwe  [3];
  logic [W-1:0] ra   [3];
  logic [W-1:0] rwd  [3];
  logic         rdy  [3];
  logic         vld  [3];
  logic         erra [3];
  logic         stl  [3];
  logic [W-1:0] rdat [3];

  exp_t         q0[$], q1[$], q2[$];
  logic [W-1:0] ref_mem [int];
  int           busy_until [3];
  logic [W-1:0] last_data  [3];
  int           errors = 0;
  int           checks = 0;
  bit           done = 1'b0;
  exp_t         e;
  logic         exp_rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.WIDTH(W), .DEPTH(D), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(rdy[0]),
    .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .err(erra[0]), .stall(stl[0]));

  data_mem_responder #(.WIDTH(W), .DEPTH(D), .READ_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(rdy[1]),
    .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .err(erra[1]), .stall(stl[1]));

  data_mem_responder #(.WIDTH(W), .DEPTH(D), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_we(rwe[2]),
    .req_addr(ra[2]), .req_wdata(rwd[2]), .req_ready(rdy[2]),
    .rsp_valid(vld[2]), .rsp_rdata(rdat[2]), .err(erra[2]), .stall(stl[2]));

  task automatic check(input string name, input int k,
                       input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, k, cyc, act, exp_v);
    end
  endtask

  function automatic void push_exp(input int k, input exp_t x);
    case (k)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endfunction

  function automatic bit pop_exp(input int k, output exp_t x);
    x = '{is_load: 1'b0, data: '0, err: 1'b0, cyc: 0};
    case (k)
      0: begin if (q0.size() == 0) return 1'b0; x = q0.pop_front(); end
      1: begin if (q1.size() == 0) return 1'b0; x = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 1'b0; x = q2.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Reference: loads return memory contents at acceptance, latency k+1.
  task automatic do_req(input int k, input logic we,
                        input logic [W-1:0] addr, input logic [W-1:0] wdata);
    int   n;
    bit   oor;
    int   key;
    exp_t x;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) if (j != k) rv[j] = 1'b0;
    rv[k] = 1'b1; rwe[k] = we; ra[k] = addr; rwd[k] = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[k] === 1'b1) break;
      n++;
      if (n > 40) begin
        $display("FAIL req_timeout inst=%0d cyc=%0d got=ready_low expected=accept", k, cyc);
        $fatal(1);
      end
      @(posedge clk); #1;
    end
    oor = (int'(addr) >= D);
    key = k * (1 << 24) + int'(addr);
    if (we) begin
      if (!oor) ref_mem[key] = wdata;
      else begin
        x = '{is_load: 1'b0, data: '0, err: 1'b1, cyc: cyc + 1};
        push_exp(k, x);
      end
    end else begin
      x = '{is_load: 1'b1, data: oor ? '0 : ref_mem[key], err: oor, cyc: cyc + k + 1};
      push_exp(k, x);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      rv[j] = 1'b0; rwe[j] = 1'($urandom_range(0, 1)); ra[j] = W'($urandom);
    end
    repeat (n - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        busy_until[k] = 0;
        last_data[k]  = '0;
        check("reset_rsp_valid", k, W'(vld[k]), '0);
        check("reset_req_ready", k, W'(rdy[k]), W'(1));
        check("reset_rsp_rdata", k, rdat[k], '0);
        check("reset_err", k, W'(erra[k]), '0);
      end else begin
        exp_rdy = (cyc >= busy_until[k]);
        check("req_ready", k, W'(rdy[k]), W'(exp_rdy));
        check("stall", k, W'(stl[k]), W'(rv[k] & ~exp_rdy));
        if (rv[k] && exp_rdy && !rwe[k]) busy_until[k] = cyc + k + 1;
        if (vld[k] || erra[k]) begin
          if (!pop_exp(k, e)) begin
            check("spurious_rsp", k, W'({vld[k], erra[k]}), '0);
          end else begin
            check("rsp_valid", k, W'(vld[k]), W'(e.is_load));
            check("err", k, W'(erra[k]), W'(e.err));
            check("rsp_cycle", k, W'(cyc), W'(e.cyc));
            if (e.is_load) begin
              check("rsp_rdata", k, rdat[k], e.data);
              last_data[k] = e.data;
            end else begin
              check("rsp_rdata_hold", k, rdat[k], last_data[k]);
            end
          end
        end else begin
          check("rsp_rdata_hold", k, rdat[k], last_data[k]);
        end
      end
    end
    if (done) begin
      for (int k = 0; k < 3; k++) check("queue_drained", k, W'(qsize(k)), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=no_finish expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    for (int j = 0; j < 3; j++) begin
      rv[j] = 1'b0; rwe[j] = 1'b0; ra[j] = '0; rwd[j] = '0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // READ_LAT=2: store then load, then a store held through the wait cycle.
    do_req(1, 1'b1, 24'd5, 24'hABCDEF);
    do_req(1, 1'b0, 24'd5, '0);
    do_req(1, 1'b1, 24'd6, 24'h111111);
    do_req(1, 1'b0, 24'd6, '0);
    idle(4);

    // READ_LAT=1: fully pipelined back-to-back loads.
    do_req(0, 1'b1, 24'd0, 24'h000011);
    do_req(0, 1'b1, 24'd1, 24'h000022);
    do_req(0, 1'b1, 24'd2, 24'h000033);
    do_req(0, 1'b0, 24'd0, '0);
    do_req(0, 1'b0, 24'd1, '0);
    do_req(0, 1'b0, 24'd2, '0);
    idle(3);

    // READ_LAT=3: second load held until the first one's response cycle.
    do_req(2, 1'b1, 24'd7, 24'h070707);
    do_req(2, 1'b1, 24'd8, 24'h080808);
    do_req(2, 1'b0, 24'd7, '0);
    do_req(2, 1'b0, 24'd8, '0);
    idle(5);

    for (int j = 0; j < 3; j++) begin
      do_req(j, 1'b1, 24'd0, 24'h5A5A5A);
      do_req(j, 1'b1, 24'd1024, 24'h123456);
      do_req(j, 1'b0, 24'd0, '0);
      do_req(j, 1'b1, 24'd1023, 24'h0F0F0F);
      do_req(j, 1'b0, 24'd1023, '0);
      do_req(j, 1'b0, 24'hFFFFFF, '0);
      do_req(j, 1'b0, 24'd1024, '0);
      do_req(j, 1'b1, 24'd9, 24'h0000AA);
      do_req(j, 1'b0, 24'd9, '0);
    end
    idle(5);

    // Reset in the wait cycle of a READ_LAT=2 load: the response must vanish.
    do_req(1, 1'b0, 24'd5, '0);
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) rv[j] = 1'b0;
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(4);
    do_req(1, 1'b0, 24'd5, '0);
    idle(4);

    for (int j = 0; j < 3; j++)
      for (int a = 0; a < 32; a++) do_req(j, 1'b1, W'(a), W'($urandom));

    repeat (300) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 45)      do_req(k, 1'b0, W'($urandom_range(0, 31)), '0);
      else if (r < 80) do_req(k, 1'b1, W'($urandom_range(0, 31)), W'($urandom));
      else if (r < 88) do_req(k, 1'($urandom_range(0, 1)),
                              W'($urandom_range(1024, 24'hFFFFFF)), W'($urandom));
      else             idle($urandom_range(1, 3));
    end
    idle(6);
    done = 1'b1;
  end

endmodule
